// File: rtl/sum_accumulator.sv
// sum_accumulator: registered accumulation stage behind the 4-bit ripple adder.
// Takes {cout, sum} as a 5-bit operand over a valid/ready handshake and adds
// NUM_SAMPLES operands into an ACC_W-bit total, then flags done and any overflow.
// Optional feature macro: SUM_ACCUMULATOR_SAT_EN (saturate instead of wrap).
//
// Handshake: an operand transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state, so it never waits on in_valid.
// An operand offered while in_ready=0 is neither latched nor remembered.
module sum_accumulator #(
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             cout,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       count,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(NUM_SAMPLES - 1);

    state_t           state;
    state_t           state_next;
    logic             start_run;
    logic             xfer;
    logic             last_xfer;
    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] acc_next;

    // Handshake and datapath decode; the adder is one bit wider to expose the carry
    always_comb begin
        start_run = 1'b0;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        operand   = {{(ACC_W-4){1'b0}}, cout, sum};
        add_full  = {1'b0, acc_out} + operand;
        acc_next  = add_full[ACC_W-1:0];
        if ((state == IDLE || state == DONE) && start) begin
            start_run = 1'b1;
        end
        if (state == ACCUM && in_valid) begin
            xfer      = 1'b1;
            last_xfer = (count == LAST_COUNT);
        end
`ifdef SUM_ACCUMULATOR_SAT_EN
        // Once the total pins at all-ones every nonzero add overflows again,
        // so it stays pinned until the next start clears it.
        if (add_full[ACC_W]) begin
            acc_next = '1;
        end
`endif
    end

    // Next-state logic; start is only honoured outside ACCUM
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_run) state_next = ACCUM;
            ACCUM:   if (last_xfer) state_next = DONE;
            DONE:    if (start_run) state_next = ACCUM;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, operand count and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else if (start_run) begin
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else if (xfer) begin
            acc_out <= acc_next;
            count   <= count + 4'd1;
            if (add_full[ACC_W]) begin
                ovf <= 1'b1;
            end
        end
    end

    // Status outputs decode straight from the state register
    always_comb begin
        in_ready = (state == ACCUM);
        done     = (state == DONE);
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed bench for sum_accumulator with hand-computed totals.
// Runs a default instance (ACC_W=8) and a narrow instance (ACC_W=6) for overflow.
module tb_sum_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start6;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;

    logic       in_ready;
    logic [7:0] acc_out;
    logic [3:0] count;
    logic       done;
    logic       ovf;

    logic       in_ready6;
    logic [5:0] acc_out6;
    logic [3:0] count6;
    logic       done6;
    logic       ovf6;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    sum_accumulator #(.ACC_W(8), .NUM_SAMPLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .cout     (cout),
        .acc_out  (acc_out),
        .count    (count),
        .done     (done),
        .ovf      (ovf)
    );

    sum_accumulator #(.ACC_W(6), .NUM_SAMPLES(4)) dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start6),
        .in_valid (in_valid),
        .in_ready (in_ready6),
        .sum      (sum),
        .cout     (cout),
        .acc_out  (acc_out6),
        .count    (count6),
        .done     (done6),
        .ovf      (ovf6)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic valid, input logic [4:0] op);
        in_valid = valid;
        {cout, sum} = op;
    endtask

    // Offer one operand for one cycle and compare against the next queued total
    task automatic xfer_check(input string tag, input logic [4:0] op);
        logic [7:0] exp;
        set_op(1'b1, op);
        tick();
        exp = exp_q.pop_front();
        check(tag, 32'(acc_out), 32'(exp));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start6   = 1'b0;
        in_valid = 1'b0;
        sum      = 4'd0;
        cout     = 1'b0;

        // Reset values
        #2;
        check("rst_acc", 32'(acc_out), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(ovf), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Backpressure in IDLE: operand 31 offered, nothing taken
        set_op(1'b1, 5'd31);
        tick();
        tick();
        check("idle_bp_ready", 32'(in_ready), 0);
        check("idle_bp_acc", 32'(acc_out), 0);
        check("idle_bp_count", 32'(count), 0);

        // Start then 15, 28, 15, 28 back to back
        set_op(1'b0, 5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", 32'(in_ready), 1);
        check("start_acc", 32'(acc_out), 0);
        exp_q.push_back(8'd15);
        exp_q.push_back(8'd43);
        exp_q.push_back(8'd58);
        exp_q.push_back(8'd86);
        xfer_check("run_t1", 5'b0_1111);
        check("run_cnt1", 32'(count), 1);
        xfer_check("run_t2", 5'b1_1100);
        xfer_check("run_t3", 5'b0_1111);
        check("run_ready3", 32'(in_ready), 1);
        xfer_check("run_t4", 5'b1_1100);
        check("run_count", 32'(count), 4);
        check("run_done", 32'(done), 1);
        check("run_ready_drop", 32'(in_ready), 0);
        check("run_ovf", 32'(ovf), 0);

        // Backpressure in DONE
        set_op(1'b1, 5'd31);
        tick();
        tick();
        check("done_bp_acc", 32'(acc_out), 86);
        check("done_bp_count", 32'(count), 4);
        check("done_bp_ready", 32'(in_ready), 0);
        check("done_bp_done", 32'(done), 1);

        // Restart from DONE (in_valid still high, must not transfer)
        start = 1'b1;
        tick();
        start = 1'b0;
        set_op(1'b0, 5'd0);
        check("restart_acc", 32'(acc_out), 0);
        check("restart_count", 32'(count), 0);
        check("restart_ovf", 32'(ovf), 0);
        check("restart_done", 32'(done), 0);
        check("restart_ready", 32'(in_ready), 1);

        // Gapped valid 1,0,0,1,1,0,1 with operand 1
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            for (int i = 0; i < 7; i++) begin
                set_op(pat[i], 5'd1);
                tick();
            end
        end
        set_op(1'b0, 5'd0);
        check("gap_acc", 32'(acc_out), 4);
        check("gap_count", 32'(count), 4);
        check("gap_done", 32'(done), 1);

        // Overflow on the ACC_W=6 instance: 31 four times
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        check("ovf_ready6", 32'(in_ready6), 1);
        set_op(1'b1, 5'd31);
        tick();
        tick();
        check("ovf_pre6", 32'(ovf6), 0);
        check("ovf_acc62", 32'(acc_out6), 62);
        tick();
        check("ovf_set6", 32'(ovf6), 1);
        tick();
        set_op(1'b0, 5'd0);
`ifdef SUM_ACCUMULATOR_SAT_EN
        check("ovf_acc6", 32'(acc_out6), 63);
`else
        check("ovf_acc6", 32'(acc_out6), 60);
`endif
        check("ovf_sticky6", 32'(ovf6), 1);
        check("ovf_done6", 32'(done6), 1);
        check("ovf_other_acc", 32'(acc_out), 4);

        // Mid-run reset after two transfers of 15
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(8'd15);
        exp_q.push_back(8'd30);
        xfer_check("mid_t1", 5'd15);
        xfer_check("mid_t2", 5'd15);
        set_op(1'b0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", 32'(acc_out), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_ovf6", 32'(ovf6), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(in_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(8'd5);
        xfer_check("fresh_t1", 5'd5);
        set_op(1'b0, 5'd0);
        check("fresh_count", 32'(count), 1);
        check("fresh_done", 32'(done), 0);
        tick();
        check("fresh_hold", 32'(acc_out), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
